// File: rtl/led_scroll_ctrl.sv
// LED matrix scroller: row-scans a MSG_LEN-character message buffer and scrolls it one line per step.
// Optional character-boundary pause is compiled in with `define LED_SCROLL_HOLD_EN.
module led_scroll_ctrl #(
  parameter int unsigned SCAN_DIV   = 4096,
  parameter int unsigned STEP_DIV   = 1024,
  parameter int unsigned MSG_LEN    = 8,
  parameter int unsigned HOLD_STEPS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       loop_en,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
  input  logic [3:0]                 wr_data,
  output logic [7:0]                 row,
  output logic [6:0]                 rom_addr,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned AW     = $clog2(MSG_LEN);
  localparam int unsigned POS_W  = AW + 3;
  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam int unsigned STEP_W = $clog2(STEP_DIV + 1);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(MSG_LEN * 8 - 1);

  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("SCAN_DIV must be at least 2");
  end
  if (STEP_DIV < 1) begin : g_bad_step_div
    $error("STEP_DIV must be at least 1");
  end
  if (MSG_LEN < 2 || MSG_LEN > 16 || (MSG_LEN & (MSG_LEN - 1)) != 0) begin : g_bad_msg_len
    $error("MSG_LEN must be a power of 2 in 2..16");
  end
  if (HOLD_STEPS < 1) begin : g_bad_hold_steps
    $error("HOLD_STEPS must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCROLL = 2'd1,
    S_DONE   = 2'd3
`ifdef LED_SCROLL_HOLD_EN
    , S_HOLD = 2'd2
`endif
  } state_t;

  state_t              state, state_nxt;
  logic [3:0]          msg_buf [MSG_LEN];
  logic [SCAN_W-1:0]   scan_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic [2:0]          r;
  logic [POS_W-1:0]    pos;
  logic [POS_W-1:0]    pos_inc;
  logic [POS_W-1:0]    line_pos;
  logic [7:0]          row_q;
  logic [6:0]          rom_q;
  logic                run;
  logic                scan_tick;
  logic                step_tick;

`ifdef LED_SCROLL_HOLD_EN
  localparam int unsigned HOLD_CW = $clog2(HOLD_STEPS + 1);
  logic [HOLD_CW-1:0] hold_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              hold_cnt <= '0;
    else if (state != S_HOLD)              hold_cnt <= '0;
    else if (step_tick)                    hold_cnt <= hold_cnt + HOLD_CW'(1);
  end

  assign run = (state == S_SCROLL) || (state == S_HOLD);
`else
  assign run = (state == S_SCROLL);
`endif

  assign scan_tick = run && (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign step_tick = scan_tick && (step_cnt == STEP_W'(STEP_DIV - 1));
  assign pos_inc   = pos + POS_W'(1);
  // Line position wraps naturally because MSG_LEN*8 is a power of two.
  assign line_pos  = pos + POS_W'(r);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start && !stop) state_nxt = S_SCROLL;
      S_SCROLL: begin
        if (stop)
          state_nxt = S_IDLE;
        else if (step_tick) begin
          if (pos == POS_MAX && !loop_en)
            state_nxt = S_DONE;
`ifdef LED_SCROLL_HOLD_EN
          else if (pos_inc[2:0] == 3'd0)
            state_nxt = S_HOLD;
`endif
        end
      end
`ifdef LED_SCROLL_HOLD_EN
      S_HOLD: begin
        if (stop)
          state_nxt = S_IDLE;
        else if (step_tick && hold_cnt == HOLD_CW'(HOLD_STEPS - 1))
          state_nxt = S_SCROLL;
      end
`endif
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    row      = run ? row_q : 8'd0;
    rom_addr = run ? rom_q : 7'd0;
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(MSG_LEN); i++) msg_buf[i] <= 4'd0;
    end else if (wr_en) begin
      msg_buf[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      step_cnt <= '0;
      r        <= 3'd0;
      pos      <= '0;
      row_q    <= 8'd0;
      rom_q    <= 7'd0;
    end else begin
      if (!run) begin
        scan_cnt <= '0;
        step_cnt <= '0;
      end else if (scan_tick) begin
        scan_cnt <= '0;
        step_cnt <= step_tick ? '0 : step_cnt + STEP_W'(1);
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end

      if (state == S_IDLE) begin
        pos <= '0;
        r   <= 3'd0;
      end else begin
        if (scan_tick) r <= r + 3'd1;
        if (state == S_SCROLL && step_tick) pos <= pos_inc;
      end

      // The buffer is read at the tick edge, so a write lands on the following tick.
      if (scan_tick) begin
        row_q <= 8'd1 << r;
        rom_q <= {msg_buf[line_pos[POS_W-1:3]], line_pos[2:0]};
      end else if (!run) begin
        row_q <= 8'd0;
        rom_q <= 7'd0;
      end
    end
  end

endmodule

// File: doc/led_scroll_ctrl.md
LED_SCROLL_CTRL -- requirements
Module: led_scroll_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  SCAN_DIV, 4096, clk cycles per row-scan tick (≥2)
  STEP_DIV, 1024, scan ticks per scroll step (≥1)
  MSG_LEN, 8, message slots (power of 2, 2..16)
  HOLD_STEPS, 8, steps held at each character boundary (used only with hold feature)
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  input  1  system clock
  rst  input  1  asynchronous active-low reset
  start  input  1  1-cycle pulse; begin scrolling
  stop  input  1  1-cycle pulse; abort to idle
  loop_en  input  1  1 = repeat message; 0 = single pass
  wr_en  input  1  message slot write strobe
  wr_addr  input  log2(MSG_LEN)  slot index
  wr_data  input  4  character code (0..15)
  row  output  8  one-hot row drive; 0 = blank
  rom_addr  output  7  character-ROM line address = code*8 + line
  busy  output  1  high outside IDLE
  done  output  1  1-cycle pulse at end of single pass

Function
REQ-003 Message buffer: MSG_LEN×4-bit registers; on wr_en the slot at wr_addr is written at the clk edge in any state.
REQ-004 A write to a slot being scanned takes effect from the next scan tick.
REQ-005 Scan tick: one-cycle pulse every SCAN_DIV clk cycles while busy; counter held at 0 in IDLE.
REQ-006 Step tick: one-cycle pulse on every STEP_DIV-th scan tick.
REQ-007 Row counter r (3 bits) increments on each scan tick, wrapping 7→0.
REQ-008 On each scan tick: row = 1<<r.
REQ-009 On each scan tick, line position p = (pos + r) mod (MSG_LEN*8).
REQ-010 On each scan tick: rom_addr = {buf[p>>3], p[2:0]}; row and rom_addr change on the same edge.
REQ-011 Scroll position pos ranges 0..MSG_LEN*8-1 and increments by 1 on each step tick in SCROLL.
REQ-012 FSM states: IDLE, SCROLL, HOLD, DONE.
REQ-013 IDLE→SCROLL on start; pos, r and the prescalers clear to 0.
REQ-014 SCROLL→HOLD when a step makes pos[2:0]==0; applies only with the hold feature compiled in.
REQ-015 HOLD→SCROLL after HOLD_STEPS step ticks; pos is frozen in HOLD.
REQ-016 SCROLL wrap: on the step from pos = MSG_LEN*8-1, with loop_en=1, pos becomes 0 and the FSM stays in SCROLL.
REQ-017 SCROLL wrap with loop_en=0: FSM goes to DONE; loop_en is sampled at the wrap step.
REQ-018 DONE lasts one cycle: done=1, then IDLE.
REQ-019 stop in any non-IDLE state → IDLE next cycle; done is not asserted.
REQ-020 start and stop in the same cycle: stop wins.
REQ-021 start while busy is ignored.
REQ-022 In IDLE and DONE: row=0 and rom_addr=0.
REQ-023 busy=1 in SCROLL, HOLD and DONE.

Reset
REQ-024 rst low asynchronously forces: FSM=IDLE, pos=0, r=0, prescalers=0, row=0, rom_addr=0, busy=0, done=0.
REQ-025 Reset clears all message slots to 0.
REQ-026 Reset asserted mid-scroll aborts immediately with no done pulse.
REQ-027 Reset release is synchronous to clk; the first active edge after deassertion sees IDLE.

Configuration
REQ-028 Macro LED_SCROLL_HOLD_EN defined: HOLD state present; scrolling pauses HOLD_STEPS steps at every character boundary, including pos=0 after a loop wrap.
REQ-029 Macro LED_SCROLL_HOLD_EN undefined: HOLD state and its counter are absent; scrolling is continuous; HOLD_STEPS is ignored.

Verification (bench parameters: SCAN_DIV=2, STEP_DIV=4, MSG_LEN=8, HOLD_STEPS=2)
REQ-030 Write slots 0..7 = 1,2,3,4,5,6,7,8, loop_en=0, start → first scan tick gives row=0x01, rom_addr=8 (code 1, line 0); next tick gives row=0x02, rom_addr=9.
REQ-031 Same setup, hold undefined → done pulses exactly once, 64 steps (512 clk) after start, then busy=0 and row=0.
REQ-032 loop_en=1 → pos wraps 63→0 with no done pulse; rom_addr at r=0 after the wrap equals 8 again.
REQ-033 stop pulsed mid-scroll together with start → IDLE next cycle; row=0, done=0, and the start is ignored.
REQ-034 rst low for 1 cycle at pos=20 → all outputs 0 immediately; wr_en to slot 3 with 9 during SCROLL → next scan hitting slot 3 gives rom_addr in 72..79.
REQ-035 LED_SCROLL_HOLD_EN defined → pos stays at 8 for 2 extra step ticks before advancing to 9.
